// File: rtl/hazard_interlock_ctrl_if.sv
// Decoder/pipeline <-> interlock scheduler signal bundle.
// The master side drives the decoded ID-stage info; the slave (scheduler) drives the stage controls.
interface hazard_interlock_ctrl_if #(
    parameter int REG_AW = 4
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_re1;
    logic              id_re2;
    logic [REG_AW-1:0] id_rd;
    logic              id_we;
    logic              id_load;
    logic              id_multi;
    logic              ex_br_taken;
    logic              mc_done;

    logic              stall_if;
    logic              stall_id;
    logic              flush_id;
    logic              bubble_ex;
    logic              hold_ex;
    logic              bubble_mem;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              mc_start;
    logic              mc_error;

    modport master (
        output id_valid, id_rs1, id_rs2, id_re1, id_re2, id_rd, id_we, id_load, id_multi,
               ex_br_taken, mc_done,
        input  stall_if, stall_id, flush_id, bubble_ex, hold_ex, bubble_mem,
               fwd_a, fwd_b, mc_start, mc_error
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_re1, id_re2, id_rd, id_we, id_load, id_multi,
               ex_br_taken, mc_done,
        output stall_if, stall_id, flush_id, bubble_ex, hold_ex, bubble_mem,
               fwd_a, fwd_b, mc_start, mc_error
    );
endinterface

// File: rtl/hazard_interlock_ctrl.sv
// Interlock scheduler for the 5-stage core: forwarding selects, load-use stalls, branch
// flushes and the start/wait handshake for the multi-cycle R-type unit.
module hazard_interlock_ctrl #(
    parameter int REG_AW     = 4,
    parameter int MC_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_interlock_ctrl_if.slave bus
);
    localparam int              CNT_W    = $clog2(MC_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               mc_error_q;
    logic               timeout;

    logic               vld_p1, we_p1, load_p1;
    logic [REG_AW-1:0]  rd_p1;
    logic               vld_p2, we_p2;
    logic [REG_AW-1:0]  rd_p2;

    logic               load_use;
    logic               stall_if_c, stall_id_c, flush_id_c, bubble_ex_c;
    logic               hold_ex_c, bubble_mem_c, mc_start_c;
    logic [1:0]         fwd_a_c, fwd_b_c;

    // A load in EX is never a forwarding source: its data only exists after MEM.
    function automatic logic [1:0] fwd_sel(
        input logic              re,
        input logic [REG_AW-1:0] rs,
        input logic              ex_vld,
        input logic              ex_we,
        input logic              ex_load,
        input logic [REG_AW-1:0] ex_rd,
        input logic              mem_vld,
        input logic              mem_we,
        input logic [REG_AW-1:0] mem_rd
    );
        if (re && ex_vld && ex_we && !ex_load && (ex_rd == rs))
            return 2'b01;
        if (re && mem_vld && mem_we && (mem_rd == rs))
            return 2'b10;
        return 2'b00;
    endfunction

    assign load_use = vld_p1 && load_p1 && we_p1 &&
                      ((bus.id_re1 && (rd_p1 == bus.id_rs1)) ||
                       (bus.id_re2 && (rd_p1 == bus.id_rs2)));

    assign timeout = (state == ST_WAIT) && !bus.mc_done && (cnt == CNT_LAST);

    always_comb begin
        state_nxt    = state;
        stall_if_c   = 1'b0;
        stall_id_c   = 1'b0;
        flush_id_c   = 1'b0;
        bubble_ex_c  = 1'b0;
        hold_ex_c    = 1'b0;
        bubble_mem_c = 1'b0;
        mc_start_c   = 1'b0;
        fwd_a_c = fwd_sel(bus.id_re1, bus.id_rs1, vld_p1, we_p1, load_p1, rd_p1,
                          vld_p2, we_p2, rd_p2);
        fwd_b_c = fwd_sel(bus.id_re2, bus.id_rs2, vld_p1, we_p1, load_p1, rd_p1,
                          vld_p2, we_p2, rd_p2);
        case (state)
            ST_IDLE: begin
                if (bus.ex_br_taken) begin
                    flush_id_c  = 1'b1;
                    bubble_ex_c = 1'b1;
                end else if (load_use) begin
                    stall_if_c  = 1'b1;
                    stall_id_c  = 1'b1;
                    bubble_ex_c = 1'b1;
                end else if (bus.id_valid && bus.id_multi) begin
                    mc_start_c = 1'b1;
                    state_nxt  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // EX is occupied by the multi-cycle op, so no branch can resolve here.
                stall_if_c   = 1'b1;
                stall_id_c   = 1'b1;
                hold_ex_c    = 1'b1;
                bubble_mem_c = 1'b1;
                if (bus.mc_done || timeout)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage boundary: ID -> EX slot (p1) -> MEM slot (p2), control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            mc_error_q <= 1'b0;
            vld_p1     <= 1'b0;
            we_p1      <= 1'b0;
            load_p1    <= 1'b0;
            vld_p2     <= 1'b0;
            we_p2      <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= ((state == ST_WAIT) && (state_nxt == ST_WAIT)) ? cnt + 1'b1 : '0;
            if (timeout)
                mc_error_q <= 1'b1;
            if (!hold_ex_c) begin
                vld_p1  <= bus.id_valid && !bubble_ex_c;
                we_p1   <= bus.id_we;
                load_p1 <= bus.id_load;
            end else if (timeout) begin
                vld_p1 <= 1'b0;
            end
            vld_p2 <= vld_p1 && !(hold_ex_c || bubble_mem_c);
            we_p2  <= we_p1;
        end
    end

    // Stage boundary: register addresses, qualified by the valid bits above.
    always_ff @(posedge clk) begin
        if (!hold_ex_c)
            rd_p1 <= bus.id_rd;
        rd_p2 <= rd_p1;
    end

    assign bus.stall_if   = rst_n && stall_if_c;
    assign bus.stall_id   = rst_n && stall_id_c;
    assign bus.flush_id   = rst_n && flush_id_c;
    assign bus.bubble_ex  = rst_n && bubble_ex_c;
    assign bus.hold_ex    = rst_n && hold_ex_c;
    assign bus.bubble_mem = rst_n && bubble_mem_c;
    assign bus.mc_start   = rst_n && mc_start_c;
    assign bus.fwd_a      = rst_n ? fwd_a_c : 2'b00;
    assign bus.fwd_b      = rst_n ? fwd_b_c : 2'b00;
    assign bus.mc_error   = mc_error_q;

endmodule

// File: tb/tb_hazard_interlock_ctrl.sv
// Directed-vector bench for hazard_interlock_ctrl with a queued scoreboard of expected outputs.
module tb_hazard_interlock_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    hazard_interlock_ctrl_if #(.REG_AW(4)) bus ();

    hazard_interlock_ctrl #(.REG_AW(4), .MC_TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Output vector: {stall_if, stall_id, flush_id, bubble_ex, hold_ex, bubble_mem, fwd_a, fwd_b, mc_start, mc_error}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110100;
    localparam logic [5:0] C_FL   = 6'b001100;
    localparam logic [5:0] C_WAIT = 6'b110011;

    string        name_q[$];
    logic [11:0]  val_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [11:0]  act;

    assign act = {bus.stall_if, bus.stall_id, bus.flush_id, bus.bubble_ex, bus.hold_ex,
                  bus.bubble_mem, bus.fwd_a, bus.fwd_b, bus.mc_start, bus.mc_error};

    function automatic logic [11:0] ov(input logic [5:0] ctl, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic ms, input logic me);
        return {ctl, fa, fb, ms, me};
    endfunction

    task automatic drive(input logic v, input logic [3:0] rd, input logic we, input logic ld,
                         input logic mul, input logic [3:0] rs1, input logic re1,
                         input logic [3:0] rs2, input logic re2, input logic br, input logic done);
        bus.id_valid    = v;
        bus.id_rd       = rd;
        bus.id_we       = we;
        bus.id_load     = ld;
        bus.id_multi    = mul;
        bus.id_rs1      = rs1;
        bus.id_re1      = re1;
        bus.id_rs2      = rs2;
        bus.id_re2      = re2;
        bus.ex_br_taken = br;
        bus.mc_done     = done;
    endtask

    task automatic step(input string name, input logic [11:0] val);
        name_q.push_back(name);
        val_q.push_back(val);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (val_q.size() > 0) begin
            string       n;
            logic [11:0] e;
            n = name_q.pop_front();
            e = val_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b", n, act, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Reset gates every output even with active-looking inputs
        drive(1, 3, 1, 0, 1, 3, 1, 3, 1, 1, 1);
        step("reset_outs", ov(C_NONE, 2'b00, 2'b00, 0, 0));
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle_after_reset", ov(C_NONE, 2'b00, 2'b00, 0, 0));

        // Forwarding
        drive(1, 3, 1, 0, 0, 1, 1, 2, 1, 0, 0);
        step("add_r3_issue", ov(C_NONE, 2'b00, 2'b00, 0, 0));
        drive(1, 6, 1, 0, 0, 3, 1, 4, 1, 0, 0);
        step("fwd_a_ex", ov(C_NONE, 2'b01, 2'b00, 0, 0));
        drive(0, 0, 0, 0, 0, 3, 1, 7, 1, 0, 0);
        step("fwd_a_mem", ov(C_NONE, 2'b10, 2'b00, 0, 0));
        drive(1, 6, 1, 0, 0, 6, 0, 6, 1, 0, 0);
        step("fwd_b_mem_re1_off", ov(C_NONE, 2'b00, 2'b10, 0, 0));
        drive(1, 6, 1, 0, 0, 6, 1, 0, 0, 0, 0);
        step("fwd_a_ex_r6", ov(C_NONE, 2'b01, 2'b00, 0, 0));
        drive(0, 0, 0, 0, 0, 6, 1, 6, 1, 0, 0);
        step("fwd_ex_priority", ov(C_NONE, 2'b01, 2'b01, 0, 0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("no_read_no_fwd", ov(C_NONE, 2'b00, 2'b00, 0, 0));

        // Load-use
        drive(1, 5, 1, 1, 0, 0, 1, 0, 0, 0, 0);
        step("load_r5_issue", ov(C_NONE, 2'b00, 2'b00, 0, 0));
        drive(1, 1, 1, 0, 0, 2, 1, 5, 1, 0, 0);
        step("load_use_stall", ov(C_LU, 2'b00, 2'b00, 0, 0));
        step("load_use_fwd_b", ov(C_NONE, 2'b00, 2'b10, 0, 0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("after_load_use", ov(C_NONE, 2'b00, 2'b00, 0, 0));
        step("drain", ov(C_NONE, 2'b00, 2'b00, 0, 0));

        // Branch flush beats load-use and multi start
        drive(1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step("load_r5_again", ov(C_NONE, 2'b00, 2'b00, 0, 0));
        drive(1, 7, 1, 0, 1, 5, 0, 5, 1, 1, 0);
        step("flush_over_load_use", ov(C_FL, 2'b00, 2'b00, 0, 0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("after_flush_idle", ov(C_NONE, 2'b00, 2'b00, 0, 0));

        // Multi-cycle op, done after 5 WAIT cycles
        drive(1, 8, 1, 0, 1, 9, 1, 0, 0, 0, 0);
        step("fft_start", ov(C_NONE, 2'b00, 2'b00, 1, 0));
        drive(1, 10, 1, 0, 0, 8, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step("fft_wait", ov(C_WAIT, 2'b01, 2'b00, 0, 0));
        drive(1, 10, 1, 0, 0, 8, 1, 0, 0, 0, 1);
        step("fft_wait_done", ov(C_WAIT, 2'b01, 2'b00, 0, 0));
        step("fft_exit_done_ignored", ov(C_NONE, 2'b01, 2'b00, 0, 0));
        drive(0, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0);
        step("fft_result_mem", ov(C_NONE, 2'b10, 2'b00, 0, 0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle_post_fft", ov(C_NONE, 2'b00, 2'b00, 0, 0));

        // Timeout after 8 WAIT cycles
        drive(1, 11, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        step("timeout_start", ov(C_NONE, 2'b00, 2'b00, 1, 0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            step("timeout_wait", ov(C_WAIT, 2'b00, 2'b00, 0, 0));
        drive(0, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0);
        step("timeout_error_ex_emptied", ov(C_NONE, 2'b00, 2'b00, 0, 1));

        // Reset during the third WAIT cycle
        drive(1, 12, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        step("rst_test_start", ov(C_NONE, 2'b00, 2'b00, 1, 1));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst_test_wait1", ov(C_WAIT, 2'b00, 2'b00, 0, 1));
        step("rst_test_wait2", ov(C_WAIT, 2'b00, 2'b00, 0, 1));
        rst_n = 1'b0;
        step("rst_mid_wait", ov(C_NONE, 2'b00, 2'b00, 0, 0));
        rst_n = 1'b1;
        drive(1, 13, 1, 0, 1, 12, 1, 0, 0, 0, 0);
        step("after_rst_idle_start", ov(C_NONE, 2'b00, 2'b00, 1, 0));

        // Back-to-back: no start while still in WAIT
        drive(1, 14, 1, 0, 1, 0, 0, 0, 0, 0, 1);
        step("b2b_wait_done_no_start", ov(C_WAIT, 2'b00, 2'b00, 0, 0));
        drive(1, 14, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        step("b2b_start", ov(C_NONE, 2'b00, 2'b00, 1, 0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("b2b_done", ov(C_WAIT, 2'b00, 2'b00, 0, 0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("final_idle", ov(C_NONE, 2'b00, 2'b00, 0, 0));

        guard = 0;
        while ((val_q.size() > 0) && (guard < 10)) begin
            @(negedge clk);
            guard++;
        end
        if (val_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: pending %0d expected 0", val_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
